custom_ip_serializer: RTL and testbench

//  Transmit side of the custom-IP 4-lane nibble link. Buffers (c_even, c_odd) byte pairs and frames them

---
 rtl/custom_ip_pkg.sv | 27 ++
 rtl/custom_ip_pair_fifo.sv | 59 +++++
 rtl/custom_ip_serializer.sv | 157 +++++++++++++++
 tb/tb_custom_ip_serializer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/custom_ip_pkg.sv
// Shared types and helpers for the custom-IP 4-lane nibble link.
// Used by both the serializer and the deserializer side.
package custom_ip_pkg;

  localparam int CIP_LANES = 4;

  typedef struct packed {
    logic [7:0] even;
    logic [7:0] odd;
  } cip_pair_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GAP    = 2'd2
  } cip_state_t;

  // Phase k carries bit (7-k) and bit (3-k) of each byte, MSB-weighted slice first.
  function automatic logic [CIP_LANES-1:0] cip_nibble(cip_pair_t p, logic [1:0] k);
    logic [2:0] hi;
    logic [2:0] lo;
    hi = 3'd7 - {1'b0, k};
    lo = 3'd3 - {1'b0, k};
    return {p.even[hi], p.even[lo], p.odd[hi], p.odd[lo]};
  endfunction

endpackage

// File: rtl/custom_ip_pair_fifo.sv
// Synchronous FIFO of (even, odd) byte pairs; push ignored when full, pop ignored when empty.
// Head is the oldest entry and is only meaningful while not empty.
module custom_ip_pair_fifo
  import custom_ip_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk_75mhz,
  input  logic                              rst_n,
  input  logic                              push,
  input  cip_pair_t                         push_pair,
  input  logic                              pop,
  output cip_pair_t                         head,
  output logic                              full,
  output logic                              empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  cip_pair_t         mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_75mhz or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_pair;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Depth is a power of two, so pointers wrap naturally.
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/custom_ip_serializer.sv
// Transmit side of the custom-IP 4-lane nibble link: buffers byte pairs and frames them
// into FRAME_GROUPS groups of 4 nibbles bracketed by enable_out.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | no frame; waits for frame_go
//   S_ACTIVE | emitting nibbles; phase/group_cnt name the nibble on data_out
//   S_GAP    | enable_out low, inter-frame spacing counting down
module custom_ip_serializer
  import custom_ip_pkg::*;
#(
  parameter int FRAME_GROUPS = 324,
  parameter int FIFO_DEPTH   = 4,
  parameter int MIN_GAP      = 2
) (
  input  logic       clk_75mhz,
  input  logic       rst_n,
  input  logic       frame_go,
  input  logic       pair_valid_in,
  input  logic [7:0] c_even_in,
  input  logic [7:0] c_odd_in,
  output logic       pair_ready,
  output logic [3:0] data_out,
  output logic       enable_out,
  output logic       frame_busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int GW   = $clog2(FRAME_GROUPS + 1);
  localparam int GAPW = $clog2(MIN_GAP + 1);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);

  cip_state_t      state, state_nxt;
  logic [1:0]      phase, phase_nxt;
  logic [GW-1:0]   group_cnt, group_nxt;
  logic [GAPW-1:0] gap_cnt, gap_nxt;
  cip_pair_t       hold, hold_nxt;
  logic [3:0]      data_nxt;
  logic            enable_nxt;
  logic            done_nxt;
  logic            underrun_nxt;
  logic            emit;
  logic            last_nibble;

  cip_pair_t       fifo_head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            fifo_push;
  logic            fifo_pop;

  assign pair_ready  = !fifo_full;
  assign fifo_push   = pair_valid_in && pair_ready;
  assign frame_busy  = (state != S_IDLE);
  assign last_nibble = (phase == 2'd3) && (group_cnt == GW'(FRAME_GROUPS - 1));

  custom_ip_pair_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_pair_fifo (
    .clk_75mhz (clk_75mhz),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_pair ({c_even_in, c_odd_in}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk_75mhz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      phase      <= '0;
      group_cnt  <= '0;
      gap_cnt    <= '0;
      hold       <= '0;
      data_out   <= '0;
      enable_out <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      group_cnt  <= group_nxt;
      gap_cnt    <= gap_nxt;
      hold       <= hold_nxt;
      data_out   <= data_nxt;
      enable_out <= enable_nxt;
      frame_done <= done_nxt;
      underrun   <= underrun_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase;
    group_nxt    = group_cnt;
    gap_nxt      = gap_cnt;
    hold_nxt     = hold;
    data_nxt     = '0;
    enable_nxt   = 1'b0;
    done_nxt     = 1'b0;
    underrun_nxt = 1'b0;
    fifo_pop     = 1'b0;
    emit         = 1'b0;

    case (state)
      S_IDLE: begin
        if (frame_go && (gap_cnt == '0)) begin
          state_nxt = S_ACTIVE;
          phase_nxt = '0;
          group_nxt = '0;
          emit      = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (last_nibble) begin
          state_nxt = S_GAP;
          gap_nxt   = GAPW'(MIN_GAP - 1);
        end else begin
          emit      = 1'b1;
          phase_nxt = phase + 2'd1;
          if (phase == 2'd3) begin
            group_nxt = group_cnt + 1'b1;
          end
        end
      end
      S_GAP: begin
        // IDLE itself costs one low cycle, so leave as the count reaches zero.
        if (gap_cnt <= GAPW'(1)) begin
          gap_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          gap_nxt = gap_cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (emit) begin
      enable_nxt = 1'b1;
      if (phase_nxt == 2'd0) begin
        // A pair pushed on this same edge is not visible yet; the group underruns.
        fifo_pop     = !fifo_empty;
        underrun_nxt = (fifo_count == '0);
        hold_nxt     = fifo_empty ? cip_pair_t'('0) : fifo_head;
      end
      data_nxt = cip_nibble(hold_nxt, phase_nxt);
      done_nxt = (phase_nxt == 2'd3) && (group_nxt == GW'(FRAME_GROUPS - 1));
    end
  end

endmodule

// File: tb/tb_custom_ip_serializer.sv
// Directed-plus-random bench for custom_ip_serializer against a queue-based frame model.
module tb_custom_ip_serializer;

  localparam int FG    = 4;
  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  logic       clk_75mhz;
  logic       rst_n;
  logic       frame_go;
  logic       pair_valid_in;
  logic [7:0] c_even_in;
  logic [7:0] c_odd_in;
  logic       pair_ready;
  logic [3:0] data_out;
  logic       enable_out;
  logic       frame_busy;
  logic       frame_done;
  logic       underrun;

  custom_ip_serializer #(
    .FRAME_GROUPS (FG),
    .FIFO_DEPTH   (DEPTH),
    .MIN_GAP      (GAP)
  ) dut (
    .clk_75mhz     (clk_75mhz),
    .rst_n         (rst_n),
    .frame_go      (frame_go),
    .pair_valid_in (pair_valid_in),
    .c_even_in     (c_even_in),
    .c_odd_in      (c_odd_in),
    .pair_ready    (pair_ready),
    .data_out      (data_out),
    .enable_out    (enable_out),
    .frame_busy    (frame_busy),
    .frame_done    (frame_done),
    .underrun      (underrun)
  );

  initial clk_75mhz = 1'b0;
  always #5 clk_75mhz = ~clk_75mhz;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Reference model: FIFO contents, position of the nibble on the link, low cycles since last frame.
  logic [15:0] m_q[$];
  int          m_pos = -1;
  int          m_low = 1000;
  logic [15:0] m_hold = '0;

  int en_cnt;
  int unr_cnt;
  int done_cnt;
  int done_at;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_nib(input logic [15:0] pr, input int k);
    int e;
    int o;
    int v;
    e = int'(pr[15:8]);
    o = int'(pr[7:0]);
    v = (((e >> (7 - k)) & 1) << 3) | (((e >> (3 - k)) & 1) << 2) |
        (((o >> (7 - k)) & 1) << 1) | ((o >> (3 - k)) & 1);
    return 4'(v);
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_pos  = -1;
    m_low  = 1000;
    m_hold = '0;
  endfunction

  task automatic tick(input logic go, input logic valid, input logic [7:0] ev, input logic [7:0] od);
    logic       rdy_exp;
    logic       exp_en;
    logic       exp_done;
    logic       exp_unr;
    logic       exp_busy;
    logic [3:0] exp_data;
    frame_go      = go;
    pair_valid_in = valid;
    c_even_in     = ev;
    c_odd_in      = od;
    rdy_exp = (m_q.size() < DEPTH);
    chk("pair_ready", {7'd0, pair_ready}, {7'd0, rdy_exp});
    exp_unr = 1'b0;
    if (m_pos >= 0) begin
      if (m_pos == 4 * FG - 1) begin
        m_pos = -1;
        m_low = 1;
      end else begin
        m_pos++;
      end
    end else if (go && m_low >= GAP) begin
      m_pos = 0;
    end else if (m_low < 1000) begin
      m_low++;
    end
    if (m_pos >= 0 && (m_pos % 4) == 0) begin
      if (m_q.size() > 0) begin
        m_hold = m_q.pop_front();
      end else begin
        m_hold  = '0;
        exp_unr = 1'b1;
      end
    end
    if (valid && rdy_exp) m_q.push_back({ev, od});
    exp_en   = (m_pos >= 0);
    exp_data = exp_en ? ref_nib(m_hold, m_pos % 4) : 4'h0;
    exp_done = (m_pos == 4 * FG - 1);
    exp_busy = (m_pos >= 0) || (m_low < GAP);
    @(posedge clk_75mhz);
    #1;
    chk("data_out",   {4'd0, data_out},   {4'd0, exp_data});
    chk("enable_out", {7'd0, enable_out}, {7'd0, exp_en});
    chk("frame_done", {7'd0, frame_done}, {7'd0, exp_done});
    chk("underrun",   {7'd0, underrun},   {7'd0, exp_unr});
    chk("frame_busy", {7'd0, frame_busy}, {7'd0, exp_busy});
    if (enable_out) en_cnt++;
    if (underrun) unr_cnt++;
    if (frame_done) begin
      done_cnt++;
      done_at = en_cnt;
    end
  endtask

  task automatic clear_counts();
    en_cnt   = 0;
    unr_cnt  = 0;
    done_cnt = 0;
    done_at  = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    rst_n         = 1'b0;
    frame_go      = 1'b0;
    pair_valid_in = 1'b0;
    c_even_in     = '0;
    c_odd_in      = '0;
    clear_counts();
    repeat (2) @(posedge clk_75mhz);
    #1;
    chk("rst_data",   {4'd0, data_out},   8'h00);
    chk("rst_enable", {7'd0, enable_out}, 8'h00);
    chk("rst_done",   {7'd0, frame_done}, 8'h00);
    chk("rst_unr",    {7'd0, underrun},   8'h00);
    chk("rst_busy",   {7'd0, frame_busy}, 8'h00);
    chk("rst_ready",  {7'd0, pair_ready}, 8'h01);
    rst_n = 1'b1;

    // Preloaded frame with A5/3C first.
    clear_counts();
    tick(1'b0, 1'b1, 8'hA5, 8'h3C);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 8'($urandom), 8'($urandom));
    tick(1'b1, 1'b0, 8'h00, 8'h00);
    chk("t1_nib0", {4'd0, data_out}, 8'h09);
    tick(1'b0, 1'b0, 8'h00, 8'h00);
    chk("t1_nib1", {4'd0, data_out}, 8'h05);
    tick(1'b0, 1'b0, 8'h00, 8'h00);
    chk("t1_nib2", {4'd0, data_out}, 8'h0A);
    tick(1'b0, 1'b0, 8'h00, 8'h00);
    chk("t1_nib3", {4'd0, data_out}, 8'h06);
    idle(16);
    chk("t1_en_cycles", 8'(en_cnt), 8'd16);
    chk("t1_done_at",   8'(done_at), 8'd16);
    chk("t1_unr",       8'(unr_cnt), 8'd0);

    // Underrun at group 2: two pairs preloaded, third arrives after group 2's pop edge.
    clear_counts();
    tick(1'b0, 1'b1, 8'h12, 8'h34);
    tick(1'b0, 1'b1, 8'h56, 8'h78);
    tick(1'b1, 1'b0, 8'h00, 8'h00);
    idle(8);
    tick(1'b0, 1'b1, 8'hC3, 8'h99);
    idle(10);
    chk("t3_en_cycles", 8'(en_cnt), 8'd16);
    chk("t3_unr",       8'(unr_cnt), 8'd1);
    chk("t3_done",      8'(done_cnt), 8'd1);

    // frame_go held high: three back-to-back frames with exactly GAP low cycles between.
    clear_counts();
    for (int i = 0; i < 3 * 4 * FG + 2 * GAP; i++)
      tick(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    chk("t4_en_cycles", 8'(en_cnt), 8'(3 * 4 * FG));
    chk("t4_done",      8'(done_cnt), 8'd3);
    idle(4);

    // Fill the FIFO past full, then run a frame with continuous valid.
    for (int i = 0; i < DEPTH + 2; i++) tick(1'b0, 1'b1, 8'($urandom), 8'($urandom));
    chk("t5_ready_full", {7'd0, pair_ready}, 8'h00);
    clear_counts();
    for (int i = 0; i < 4 * FG + 4; i++) tick(i == 0, 1'b1, 8'($urandom), 8'($urandom));
    chk("t5_unr", 8'(unr_cnt), 8'd0);

    // Random traffic over several frames.
    for (int i = 0; i < 300; i++)
      tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom));
    idle(4 * FG + 4);

    // Asynchronous reset during group 1 phase 2.
    for (int i = 0; i < DEPTH; i++) tick(1'b0, 1'b1, 8'hFF, 8'hFF);
    tick(1'b1, 1'b0, 8'h00, 8'h00);
    idle(6);
    chk("t6_pre_enable", {7'd0, enable_out}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_enable", {7'd0, enable_out}, 8'h00);
    chk("t6_async_data",   {4'd0, data_out},   8'h00);
    @(posedge clk_75mhz);
    #1;
    rst_n = 1'b1;
    model_reset();
    chk("t6_busy",  {7'd0, frame_busy}, 8'h00);
    chk("t6_ready", {7'd0, pair_ready}, 8'h01);
    clear_counts();
    tick(1'b1, 1'b0, 8'h00, 8'h00);
    chk("t6_empty_unr", {7'd0, underrun}, 8'h01);
    idle(4 * FG + 3);
    chk("t6_en_cycles", 8'(en_cnt), 8'd16);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
